// File: rtl/hex_sched_pkg.sv
// Shared definitions for the hex display scheduler: state encoding,
// display/source-index widths and a small sizing helper.
package hex_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHOW  = 2'd1,
      BLANK = 2'd2
   } state_t;

   localparam int DISP_W    = 16;
   localparam int SRC_IDX_W = 3;

   // Largest of three values, used to size the shared dwell/blank counter.
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/hex_display_scheduler_rr_arbiter.sv
// Rotate-priority arbiter: grants the first request strictly after ptr,
// wrapping modulo NUM_SRC, so the pointer's own source is considered last.
module rr_arbiter
   import hex_sched_pkg::*;
#(
   parameter int NUM_SRC = 4
) (
   input  logic [NUM_SRC-1:0]   req,
   input  logic [SRC_IDX_W-1:0] ptr,
   output logic [SRC_IDX_W-1:0] grant_idx,
   output logic                 grant_any
);

   // Walk candidates ptr+1 .. ptr+NUM_SRC and take the first requester.
   always_comb begin
      int cand;
      grant_idx = '0;
      grant_any = 1'b0;
      cand      = 0;
      for (int k = 1; k <= NUM_SRC; k++) begin
         cand = (int'(ptr) + k) % NUM_SRC;
         for (int i = 0; i < NUM_SRC; i++) begin
            if (!grant_any && (i == cand) && req[i]) begin
               grant_any = 1'b1;
               grant_idx = SRC_IDX_W'(i);
            end
         end
      end
   end

endmodule

// File: rtl/hex_display_scheduler.sv
// Round-robin scheduler that snapshots one of NUM_SRC 16-bit status words,
// holds it on the hex display for DWELL_CYCLES, then blanks for BLANK_CYCLES.
// Optional build macro HEX_SCHED_PIN_EN adds pin_en/pin_sel to show one
// source live, bypassing arbitration.
module hex_display_scheduler
   import hex_sched_pkg::*;
#(
   parameter int NUM_SRC      = 4,
   parameter int DWELL_CYCLES = 50_000_000,
   parameter int BLANK_CYCLES = 5_000_000
) (
   input  logic                        clk,
   input  logic                        clr_n,
   input  logic [NUM_SRC-1:0]          src_valid,
   input  logic [DISP_W*NUM_SRC-1:0]   src_data,
`ifdef HEX_SCHED_PIN_EN
   input  logic                        pin_en,
   input  logic [SRC_IDX_W-1:0]        pin_sel,
`endif
   output logic [NUM_SRC-1:0]          src_ack,
   output logic [DISP_W-1:0]           disp_x,
   output logic                        disp_valid,
   output logic [SRC_IDX_W-1:0]        disp_src
);

   localparam int CNT_W = $clog2(max3(DWELL_CYCLES, BLANK_CYCLES, 2));
   localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [CNT_W-1:0] BLANK_LOAD =
      CNT_W'((BLANK_CYCLES > 0) ? (BLANK_CYCLES - 1) : 0);
   localparam logic [SRC_IDX_W-1:0] PTR_RST = SRC_IDX_W'(NUM_SRC - 1);

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [SRC_IDX_W-1:0]   ptr_q, ptr_d;
   logic [DISP_W-1:0]      disp_x_q, disp_x_d;
   logic                   disp_valid_q, disp_valid_d;
   logic [SRC_IDX_W-1:0]   disp_src_q, disp_src_d;
   logic [NUM_SRC-1:0]     ack_q, ack_d;

   logic [SRC_IDX_W-1:0]   grant_idx;
   logic                   grant_any;
   logic [DISP_W-1:0]      grant_word;

   rr_arbiter #(
      .NUM_SRC (NUM_SRC)
   ) u_arb (
      .req       (src_valid),
      .ptr       (ptr_q),
      .grant_idx (grant_idx),
      .grant_any (grant_any)
   );

   // Select the granted source's word from the packed input bus.
   always_comb begin
      grant_word = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (grant_idx == SRC_IDX_W'(i)) grant_word = src_data[i*DISP_W +: DISP_W];
      end
   end

`ifdef HEX_SCHED_PIN_EN
   logic [DISP_W-1:0] pin_word;
   logic              pin_in_range;

   // Live word for the pinned source; out-of-range selections read as zero.
   always_comb begin
      pin_word     = '0;
      pin_in_range = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (pin_sel == SRC_IDX_W'(i)) begin
            pin_word     = src_data[i*DISP_W +: DISP_W];
            pin_in_range = 1'b1;
         end
      end
   end
`endif

   // Next-state logic: dwell/blank sequencing and arbitration on word boundaries.
   always_comb begin
      logic do_arb;
      state_d      = state_q;
      cnt_d        = cnt_q;
      ptr_d        = ptr_q;
      disp_x_d     = disp_x_q;
      disp_valid_d = disp_valid_q;
      disp_src_d   = disp_src_q;
      ack_d        = '0;
      do_arb       = 1'b0;

      case (state_q)
         IDLE: do_arb = 1'b1;
         SHOW: begin
            if (cnt_q == '0) begin
               if (BLANK_CYCLES > 0) begin
                  cnt_d        = BLANK_LOAD;
                  disp_valid_d = 1'b0;
                  state_d      = BLANK;
               end else begin
                  // No gap configured: next word follows in the same cycle.
                  do_arb = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         BLANK: begin
            disp_valid_d = 1'b0;
            if (cnt_q == '0) do_arb = 1'b1;
            else             cnt_d  = cnt_q - 1'b1;
         end
         default: state_d = IDLE;
      endcase

      if (do_arb) begin
         if (grant_any) begin
            disp_x_d         = grant_word;
            disp_src_d       = grant_idx;
            disp_valid_d     = 1'b1;
            ack_d[grant_idx] = 1'b1;
            ptr_d            = grant_idx;
            cnt_d            = DWELL_LOAD;
            state_d          = SHOW;
         end else begin
            disp_valid_d = 1'b0;
            state_d      = IDLE;
         end
      end

`ifdef HEX_SCHED_PIN_EN
      // Pinning overrides everything: no acks, counters and pointer frozen,
      // and the FSM parks in IDLE so arbitration resumes once released.
      if (pin_en) begin
         state_d      = IDLE;
         cnt_d        = cnt_q;
         ptr_d        = ptr_q;
         ack_d        = '0;
         disp_x_d     = pin_word;
         disp_valid_d = pin_in_range;
         if (pin_in_range) disp_src_d = pin_sel;
         else              disp_src_d = disp_src_q;
      end
`endif
   end

   // State and registered outputs; reset returns everything to power-on values.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         ptr_q        <= PTR_RST;
         disp_x_q     <= '0;
         disp_valid_q <= 1'b0;
         disp_src_q   <= '0;
         ack_q        <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         ptr_q        <= ptr_d;
         disp_x_q     <= disp_x_d;
         disp_valid_q <= disp_valid_d;
         disp_src_q   <= disp_src_d;
         ack_q        <= ack_d;
      end
   end

   assign src_ack    = ack_q;
   assign disp_x     = disp_x_q;
   assign disp_valid = disp_valid_q;
   assign disp_src   = disp_src_q;

endmodule

// File: tb/tb_hex_display_scheduler.sv
// Directed bench for hex_display_scheduler: one instance with an 8-cycle
// dwell and 2-cycle blank, a second with no blank gap.
module tb_hex_display_scheduler;
   import hex_sched_pkg::*;

   logic        clk = 1'b0;
   logic        clr_n = 1'b0;

   logic [3:0]  src_valid = '0;
   logic [63:0] src_data  = '0;
   logic [3:0]  src_ack;
   logic [15:0] disp_x;
   logic        disp_valid;
   logic [2:0]  disp_src;

   logic [3:0]  z_valid = '0;
   logic [63:0] z_data  = '0;
   logic [3:0]  z_ack;
   logic [15:0] z_x;
   logic        z_vld;
   logic [2:0]  z_src;

`ifdef HEX_SCHED_PIN_EN
   logic        pin_en  = 1'b0;
   logic [2:0]  pin_sel = '0;
`endif

   int checks   = 0;
   int failures = 0;

   hex_display_scheduler #(.NUM_SRC(4), .DWELL_CYCLES(8), .BLANK_CYCLES(2)) dut (
      .clk(clk), .clr_n(clr_n), .src_valid(src_valid), .src_data(src_data),
`ifdef HEX_SCHED_PIN_EN
      .pin_en(pin_en), .pin_sel(pin_sel),
`endif
      .src_ack(src_ack), .disp_x(disp_x), .disp_valid(disp_valid), .disp_src(disp_src)
   );

   hex_display_scheduler #(.NUM_SRC(4), .DWELL_CYCLES(8), .BLANK_CYCLES(0)) dutz (
      .clk(clk), .clr_n(clr_n), .src_valid(z_valid), .src_data(z_data),
`ifdef HEX_SCHED_PIN_EN
      .pin_en(pin_en), .pin_sel(pin_sel),
`endif
      .src_ack(z_ack), .disp_x(z_x), .disp_valid(z_vld), .disp_src(z_src)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      src_valid = '0;
      z_valid   = '0;
      clr_n     = 1'b0;
      step();
      clr_n = 1'b1;
   endtask

   task automatic test_reset();
      logic [23:0] obs;
      clr_n = 1'b0;
      #3;
      obs = {disp_valid, src_ack, disp_src, disp_x};
      checks++;
      if (obs !== 24'h0) begin
         failures++;
         $display("FAIL reset_main got=%h exp=%h", obs, 24'h0);
      end
      obs = {z_vld, z_ack, z_src, z_x};
      checks++;
      if (obs !== 24'h0) begin
         failures++;
         $display("FAIL reset_noblank got=%h exp=%h", obs, 24'h0);
      end
      step();
      clr_n = 1'b1;
   endtask

   task automatic test_single();
      logic [23:0] obs, exp;
      logic        ev;
      logic [3:0]  ea;
      do_reset();
      src_data[15:0] = 16'h1234;
      src_valid      = 4'b0001;
      for (int c = 1; c <= 11; c++) begin
         step();
         ev  = (c <= 8) || (c == 11);
         ea  = (c == 1 || c == 11) ? 4'b0001 : 4'b0000;
         exp = {ev, ea, 3'd0, 16'h1234};
         obs = {disp_valid, src_ack, disp_src, disp_x};
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("FAIL single_c%0d got=%h exp=%h", c, obs, exp);
         end
      end
   endtask

   task automatic test_round_robin();
      logic [23:0] obs, exp;
      logic [15:0] words [4];
      int          s;
      words[0] = 16'hA000; words[1] = 16'hB111;
      words[2] = 16'hC222; words[3] = 16'hD333;
      do_reset();
      src_data  = {16'hD333, 16'hC222, 16'hB111, 16'hA000};
      src_valid = 4'b1111;
      step();
      exp = {1'b1, 4'b0001, 3'd0, 16'hA000};
      obs = {disp_valid, src_ack, disp_src, disp_x};
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL rr_first got=%h exp=%h", obs, exp);
      end
      for (int g = 1; g <= 4; g++) begin
         s = g % 4;
         repeat (9) step();
         exp = {1'b0, 4'b0000, 3'((g - 1) % 4), words[(g - 1) % 4]};
         obs = {disp_valid, src_ack, disp_src, disp_x};
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("FAIL rr_blank_g%0d got=%h exp=%h", g, obs, exp);
         end
         step();
         exp = {1'b1, 4'(1 << s), 3'(s), words[s]};
         obs = {disp_valid, src_ack, disp_src, disp_x};
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("FAIL rr_grant_g%0d got=%h exp=%h", g, obs, exp);
         end
      end
   endtask

   task automatic test_snapshot();
      logic [23:0] obs, exp;
      do_reset();
      src_data[15:0] = 16'h1234;
      src_valid      = 4'b0001;
      repeat (3) step();
      src_data[15:0] = 16'hFFFF;
      for (int c = 4; c <= 8; c++) begin
         step();
         exp = {1'b1, 4'b0000, 3'd0, 16'h1234};
         obs = {disp_valid, src_ack, disp_src, disp_x};
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("FAIL snap_hold_c%0d got=%h exp=%h", c, obs, exp);
         end
      end
      repeat (3) step();
      exp = {1'b1, 4'b0001, 3'd0, 16'hFFFF};
      obs = {disp_valid, src_ack, disp_src, disp_x};
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL snap_regrant got=%h exp=%h", obs, exp);
      end
   endtask

   task automatic test_drop_idle();
      logic [23:0] obs, exp;
      do_reset();
      src_data[31:16] = 16'h5555;
      src_valid       = 4'b0010;
      step();
      exp = {1'b1, 4'b0010, 3'd1, 16'h5555};
      obs = {disp_valid, src_ack, disp_src, disp_x};
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL drop_grant got=%h exp=%h", obs, exp);
      end
      repeat (3) step();
      src_valid = 4'b0000;
      for (int c = 5; c <= 13; c++) begin
         step();
         exp = {(c <= 8), 4'b0000, 3'd1, 16'h5555};
         obs = {disp_valid, src_ack, disp_src, disp_x};
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("FAIL drop_c%0d got=%h exp=%h", c, obs, exp);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [23:0] obs, exp;
      int          s;
      logic [3:0]  ea;
      do_reset();
      z_data[31:0] = {16'hBBBB, 16'hAAAA};
      z_valid      = 4'b0011;
      for (int c = 1; c <= 24; c++) begin
         step();
         s   = ((c - 1) / 8) % 2;
         ea  = ((c - 1) % 8 == 0) ? 4'(1 << s) : 4'b0000;
         exp = {1'b1, ea, 3'(s), (s == 1) ? 16'hBBBB : 16'hAAAA};
         obs = {z_vld, z_ack, z_src, z_x};
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("FAIL b2b_c%0d got=%h exp=%h", c, obs, exp);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [23:0] obs, exp;
      do_reset();
      src_data[15:0]  = 16'h1234;
      src_data[47:32] = 16'h2222;
      src_valid       = 4'b0001;
      repeat (3) step();
      #2;
      clr_n = 1'b0;
      #1;
      obs = {disp_valid, src_ack, disp_src, disp_x};
      checks++;
      if (obs !== 24'h0) begin
         failures++;
         $display("FAIL rstmid_async got=%h exp=%h", obs, 24'h0);
      end
      step();
      obs = {disp_valid, src_ack, disp_src, disp_x};
      checks++;
      if (obs !== 24'h0) begin
         failures++;
         $display("FAIL rstmid_held got=%h exp=%h", obs, 24'h0);
      end
      src_valid = 4'b0101;
      clr_n     = 1'b1;
      step();
      exp = {1'b1, 4'b0001, 3'd0, 16'h1234};
      obs = {disp_valid, src_ack, disp_src, disp_x};
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL rstmid_prio got=%h exp=%h", obs, exp);
      end
      repeat (10) step();
      exp = {1'b1, 4'b0100, 3'd2, 16'h2222};
      obs = {disp_valid, src_ack, disp_src, disp_x};
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL rstmid_next got=%h exp=%h", obs, exp);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_snapshot();
      test_drop_idle();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
